blk_ed83e0: RTL and testbench

Converts the raw byte stream arriving from the JTAG debug-master link into an Avalon-ST packet stream carrying start/end-of-packet and channel sideband. It decodes the in-band marker protocol (SOP, EOP, channel and escape characters) and feeds the dmaster channel adapter. That adapter drops every channel other than 0 before packet-to-transaction conversion. The block has a one-entry registered output, so it sustains one data byte per cycle under full backpressure compliance.

---
 rtl/blk_ed83e0_if.sv | 39 +++
 rtl/blk_ed83e0.sv | 114 +++++++++++
 tb/tb_blk_ed83e0.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/blk_ed83e0_if.sv
// Byte-in / Avalon-ST-out stream bundle for the dmaster bytes-to-packets decoder.
// The slave modport is the decoder's view; the master modport is the surrounding environment.
interface blk_ed83e0_if #(
  parameter int unsigned CHANNEL_WIDTH = 8
);
  logic                     in_ready;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic                     out_startofpacket;
  logic                     out_endofpacket;

  modport master (
    input  in_ready,
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_channel,
    input  out_startofpacket,
    input  out_endofpacket
  );

  modport slave (
    output in_ready,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_channel,
    output out_startofpacket,
    output out_endofpacket
  );
endinterface

// File: rtl/blk_ed83e0.sv
// Decodes the JTAG debug-master byte stream (SOP/EOP/channel/escape markers) into an
// Avalon-ST packet stream through a single registered output stage.
module blk_ed83e0 #(
  parameter int unsigned CHANNEL_WIDTH = 8
) (
  input logic        clk,
  input logic        reset_n,
  blk_ed83e0_if.slave bus
);
  localparam logic [7:0] SopChar  = 8'h7A;
  localparam logic [7:0] EopChar  = 8'h7B;
  localparam logic [7:0] ChanChar = 8'h7C;
  localparam logic [7:0] EscChar  = 8'h7D;

  logic                     sop_pend_q, sop_pend_d;
  logic                     eop_pend_q, eop_pend_d;
  logic                     chan_pend_q, chan_pend_d;
  logic                     esc_pend_q, esc_pend_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;

  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_data_q, out_data_d;
  logic [CHANNEL_WIDTH-1:0] out_channel_q, out_channel_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;

  logic       in_ready;
  logic       accept;
  logic       is_lit;
  logic [7:0] literal;

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    sop_pend_d    = sop_pend_q;
    eop_pend_d    = eop_pend_q;
    chan_pend_d   = chan_pend_q;
    esc_pend_d    = esc_pend_q;
    chan_d        = chan_q;
    out_valid_d   = out_valid_q & ~bus.out_ready;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    literal       = bus.in_data;
    is_lit        = 1'b0;

    if (accept) begin
      if (esc_pend_q) begin
        // Escaped bytes are always data, even when they decode to a marker code.
        literal    = bus.in_data ^ 8'h20;
        esc_pend_d = 1'b0;
        is_lit     = 1'b1;
      end else begin
        case (bus.in_data)
          SopChar:  sop_pend_d  = 1'b1;
          EopChar:  eop_pend_d  = 1'b1;
          ChanChar: chan_pend_d = 1'b1;
          EscChar:  esc_pend_d  = 1'b1;
          default:  is_lit      = 1'b1;
        endcase
      end

      if (is_lit) begin
        if (chan_pend_q) begin
          chan_d      = literal[CHANNEL_WIDTH-1:0];
          chan_pend_d = 1'b0;
        end else begin
          out_valid_d   = 1'b1;
          out_data_d    = literal;
          out_channel_d = chan_q;
          out_sop_d     = sop_pend_q;
          out_eop_d     = eop_pend_q;
          sop_pend_d    = 1'b0;
          eop_pend_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sop_pend_q    <= 1'b0;
      eop_pend_q    <= 1'b0;
      chan_pend_q   <= 1'b0;
      esc_pend_q    <= 1'b0;
      chan_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      out_channel_q <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
    end else begin
      sop_pend_q    <= sop_pend_d;
      eop_pend_q    <= eop_pend_d;
      chan_pend_q   <= chan_pend_d;
      esc_pend_q    <= esc_pend_d;
      chan_q        <= chan_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_channel       = out_channel_q;
  assign bus.out_startofpacket = out_sop_q;
  assign bus.out_endofpacket   = out_eop_q;
endmodule

// File: tb/tb_blk_ed83e0.sv
// Scoreboard bench for blk_ed83e0: a byte-level reference decoder queues expected beats,
// and an independent monitor checks every presented beat and the handshake timing.
module tb_blk_ed83e0;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [7:0]    data;
    logic [CW-1:0] ch;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  beat_t sb[$];

  blk_ed83e0_if #(.CHANNEL_WIDTH(CW)) bus ();

  blk_ed83e0 #(.CHANNEL_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached, sb_size=%0d required 0", sb.size());
    $fatal(1);
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Reference decoder: follows the marker protocol byte by byte on each accepted byte.
  logic          m_sop, m_eop, m_chp, m_esc;
  logic [CW-1:0] m_chan;

  always @(negedge clk) begin
    logic [7:0] b;
    logic [7:0] lit;
    logic       is_lit;
    beat_t      nb;
    logic       emit;
    emit = 1'b0;
    if (!reset_n) begin
      m_sop = 1'b0; m_eop = 1'b0; m_chp = 1'b0; m_esc = 1'b0; m_chan = '0;
      #2 sb.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      b      = bus.in_data;
      lit    = b;
      is_lit = 1'b0;
      if (m_esc) begin
        lit = b ^ 8'h20; m_esc = 1'b0; is_lit = 1'b1;
      end else if (b == 8'h7A) m_sop = 1'b1;
      else if (b == 8'h7B) m_eop = 1'b1;
      else if (b == 8'h7C) m_chp = 1'b1;
      else if (b == 8'h7D) m_esc = 1'b1;
      else is_lit = 1'b1;
      if (is_lit) begin
        if (m_chp) begin
          m_chan = lit[CW-1:0];
          m_chp  = 1'b0;
        end else begin
          nb    = '{data: lit, ch: m_chan, sop: m_sop, eop: m_eop};
          m_sop = 1'b0;
          m_eop = 1'b0;
          emit  = 1'b1;
        end
      end
      if (emit) #2 sb.push_back(nb);
    end
  end

  // Monitor: a queued beat must be on the output one cycle after its accept, held until taken.
  always @(negedge clk) begin
    beat_t got;
    logic  exp_rdy;
    if (reset_n) begin
      checks++;
      if (bus.out_valid !== (sb.size() != 0)) begin
        failures++;
        $display("FAIL out_valid: got %b required %b", bus.out_valid, sb.size() != 0);
      end
      exp_rdy = (sb.size() == 0) || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL in_ready: got %b required %b", bus.in_ready, exp_rdy);
      end
      if (bus.out_valid && sb.size() != 0) begin
        got = '{data: bus.out_data, ch: bus.out_channel,
                sop: bus.out_startofpacket, eop: bus.out_endofpacket};
        checks++;
        if (got !== sb[0]) begin
          failures++;
          $display("FAIL beat: got data=%h ch=%h sop=%b eop=%b required data=%h ch=%h sop=%b eop=%b",
                   got.data, got.ch, got.sop, got.eop,
                   sb[0].data, sb[0].ch, sb[0].sop, sb[0].eop);
        end
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    failures++;
    $display("FAIL send_timeout: byte %h not accepted, in_ready=%b required 1", b, bus.in_ready);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send(seq[i]);
    idle(3);
  endtask

  initial begin
    logic [7:0] s[$];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_channel, bus.out_startofpacket,
         bus.out_endofpacket, bus.in_ready} !== {1'b0, 8'h00, {CW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: got valid=%b data=%h ch=%h sop=%b eop=%b in_ready=%b required 0 00 00 0 0 1",
               bus.out_valid, bus.out_data, bus.out_channel, bus.out_startofpacket,
               bus.out_endofpacket, bus.in_ready);
    end
    @(posedge clk);
    #1;

    s = '{8'h7C, 8'h00, 8'h7A, 8'h11, 8'h22, 8'h7B, 8'h33};
    send_seq(s);
    s = '{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5C};
    send_seq(s);
    s = '{8'h7C, 8'h7D, 8'h5B, 8'h7A, 8'h7B, 8'h44};
    send_seq(s);
    s = '{8'h7A, 8'h7A, 8'h7B, 8'h7B, 8'h7C, 8'h7A, 8'h05, 8'h66};
    send_seq(s);

    // Stall with a beat pending, then stream back-to-back after release.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send(8'h7A);
    send(8'h10);
    fork
      send(8'h20);
      begin
        repeat (5) @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
    send(8'h7B);
    send(8'h40);
    idle(3);

    // Reset discards pending SOP and escape.
    send(8'h7A);
    send(8'h7D);
    do_reset();
    s = '{8'h55};
    send_seq(s);

    rdy_mode = 1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 9) < 4) send(8'(8'h7A + $urandom_range(0, 3)));
      else send(8'($urandom));
    end
    idle(2);
    rdy_mode = 0;
    idle(6);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d beats left required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
